ysyx_25060173_core_ctrl: RTL
============================

YSYX_25060173_CORE_CTRL -- requirements
Module: ysyx_25060173_core_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h80000000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 8'd255, max wait cycles for any bus response before error.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports if_req output 1 (fetch request), if_addr output 32 (fetch address, equals pc), if_ready input 1 (request accepted), if_rvalid input 1 (instruction returned), if_rdata input 32 (instruction word).
REQ-006 SHALL have port inst  output 32  instruction register, drives the instruction decoder.
REQ-007 SHALL have inputs dec_load, dec_store, dec_branch, dec_jump, dec_ebreak, each 1 bit: instruction-class flags, decoded from inst.
REQ-008 SHALL have inputs br_taken 1 (branch condition true) and br_target 32 (jump/branch destination).
REQ-009 SHALL have ports ls_req output 1 (load/store request), ls_wen output 1 (1 = store), ls_ack input 1 (access complete).
REQ-010 SHALL have outputs rf_wen 1 (register-file write strobe), pc 32 (current PC), instret 32 (retired-instruction count), halt 1 (core stopped), error 1 (bus timeout).

Function
REQ-011 SHALL implement states FETCH, IWAIT, DECODE, EXEC, MEM, WB, HALT, ERROR.
REQ-012 FETCH: if_req=1; SHALL go to IWAIT on the cycle where if_req&if_ready; otherwise stay in FETCH.
REQ-013 IWAIT: on if_rvalid, SHALL latch if_rdata into inst and go to DECODE; if_rvalid outside IWAIT SHALL be ignored.
REQ-014 DECODE: one cycle; SHALL go to HALT if dec_ebreak, else to EXEC.
REQ-015 EXEC: one cycle; SHALL go to MEM if dec_load|dec_store, else to WB.
REQ-016 MEM: ls_req=1, ls_wen=dec_store; SHALL hold both stable until ls_ack, then go to WB.
REQ-017 WB: one cycle; rf_wen=1 unless dec_store or dec_branch; SHALL then go to FETCH.
REQ-018 In WB, pc SHALL become br_target if dec_jump or (dec_branch & br_taken), else pc+4 (mod 2^32, wrap at 32'hFFFFFFFC→0).
REQ-019 In WB, instret SHALL increment by 1, wrapping 32'hFFFFFFFF→0.
REQ-020 A wait counter SHALL clear on entry to FETCH, IWAIT, MEM and increment each cycle the awaited signal is low; reaching TIMEOUT SHALL move the FSM to ERROR.
REQ-021 HALT: halt=1; ERROR: halt=1, error=1; both sticky until rst; no requests issued.
REQ-022 if_req, ls_req, rf_wen SHALL be 0 in every state not named for them above; at most one of if_req/ls_req high in any cycle.
REQ-023 inst, pc, instret SHALL change only at the points given in REQ-013, REQ-018, REQ-019.
REQ-024 Minimum latency: non-memory instruction 5 cycles (FETCH..WB) with if_ready and if_rvalid each at first opportunity; load/store 6 cycles with same-cycle ls_ack.

Reset
REQ-025 While rst=1, SHALL hold: state FETCH, pc=RESET_PC, inst=0, instret=0, wait counter 0, if_req=0, ls_req=0, ls_wen=0, rf_wen=0, halt=0, error=0.
REQ-026 rst asserted mid-transaction SHALL immediately drop if_req/ls_req without waiting for handshake completion; first if_req SHALL appear the first cycle after rst deasserts.

Verification
REQ-027 ADDI 32'h00100093 with immediate if_ready/if_rvalid -> rf_wen one cycle at cycle 5, pc 80000000→80000004, instret=1.
REQ-028 SW, ls_ack delayed 3 cycles -> ls_req=1, ls_wen=1 for 4 cycles, rf_wen never 1, pc +4.
REQ-029 BEQ with br_taken=1, br_target=32'h80000100 -> pc=80000100, rf_wen=0; repeat with br_taken=0 -> pc+4.
REQ-030 inst=32'h00100073 (ebreak) -> HALT after DECODE, halt=1, if_req stays 0 for 100 cycles, instret unchanged.
REQ-031 if_ready held 0 with TIMEOUT=8 -> error=1 and halt=1 after 8 wait cycles; then rst pulse -> all outputs per REQ-025, if_req=1 next cycle.
REQ-032 rst asserted during MEM with ls_req=1 -> ls_req=0 same cycle (asynchronous), pc=RESET_PC.

Source files
------------

// File: rtl/ysyx_25060173_core_ctrl.sv
// ysyx_25060173_core_ctrl
//
// Multi-cycle control FSM for a single-issue core. It fetches one instruction
// at a time over a request/ready + rvalid fetch bus, holds it in the
// instruction register for the external decoder, walks through decode,
// execute, an optional load/store phase and write-back, then advances the PC
// and the retired-instruction counter. Every bus wait is bounded by TIMEOUT
// cycles; running out of time parks the core in a sticky error state.
//
// Parameters
//   RESET_PC  PC value loaded while rst is high
//   TIMEOUT   max cycles to wait for if_ready / if_rvalid / ls_ack
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   if_req, if_addr               fetch request and address (the PC)
//   if_ready, if_rvalid, if_rdata fetch accept, instruction return, data
//   inst                          instruction register, feeds the decoder
//   dec_*                         instruction-class flags decoded from inst
//   br_taken, br_target           branch condition and redirect target
//   ls_req, ls_wen, ls_ack        load/store request, store flag, completion
//   rf_wen                        register-file write strobe
//   pc, instret                   current PC, retired-instruction count
//   halt, error                   core stopped, bus timeout occurred
module ysyx_25060173_core_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ready,
  input  logic        if_rvalid,
  input  logic [31:0] if_rdata,
  output logic [31:0] inst,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_branch,
  input  logic        dec_jump,
  input  logic        dec_ebreak,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        ls_req,
  output logic        ls_wen,
  input  logic        ls_ack,
  output logic        rf_wen,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halt,
  output logic        error
);

  typedef enum logic [2:0] {
    StFetch,
    StIwait,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instret_q, instret_d;
  logic [7:0]  wait_q, wait_d;
  logic [8:0]  wait_inc;
  logic        wait_expired;
  logic        redirect;

  // One extra bit so the comparison cannot wrap when TIMEOUT is 255.
  assign wait_inc     = {1'b0, wait_q} + 9'd1;
  assign wait_expired = (wait_inc >= {1'b0, TIMEOUT});
  assign redirect     = dec_jump | (dec_branch & br_taken);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    wait_d    = wait_q;

    unique case (state_q)
      StFetch: begin
        if (if_req && if_ready) begin
          state_d = StIwait;
          wait_d  = '0;
        end else if (wait_expired) begin
          state_d = StError;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end
      StIwait: begin
        if (if_rvalid) begin
          inst_d  = if_rdata;
          state_d = StDecode;
        end else if (wait_expired) begin
          state_d = StError;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end
      StDecode: begin
        state_d = dec_ebreak ? StHalt : StExec;
      end
      StExec: begin
        if (dec_load || dec_store) begin
          state_d = StMem;
          wait_d  = '0;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (ls_ack) begin
          state_d = StWb;
        end else if (wait_expired) begin
          state_d = StError;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end
      StWb: begin
        pc_d      = redirect ? br_target : pc_q + 32'd4;
        instret_d = instret_q + 32'd1;
        state_d   = StFetch;
        wait_d    = '0;
      end
      StHalt:  state_d = StHalt;
      StError: state_d = StError;
      default: state_d = StError;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
    end
  end

  // Outputs decode the registered state only. The request strobes are also
  // gated by rst so that, although the reset state is FETCH, nothing is
  // requested while rst is held and an in-flight request drops at once.
  assign if_req  = (state_q == StFetch) & ~rst;
  assign ls_req  = (state_q == StMem) & ~rst;
  assign ls_wen  = ls_req & dec_store;
  assign rf_wen  = (state_q == StWb) & ~(dec_store | dec_branch) & ~rst;
  assign halt    = (state_q == StHalt) | (state_q == StError);
  assign error   = (state_q == StError);
  assign if_addr = pc_q;
  assign pc      = pc_q;
  assign inst    = inst_q;
  assign instret = instret_q;

endmodule
